// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 host receiver: the frame FSM state
// encoding and the fixed PS/2 frame constants.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   localparam logic PS2_START_BIT = 1'b0;
   localparam logic PS2_STOP_BIT  = 1'b1;
   localparam int   PS2_DATA_BITS = 8;

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
// Brings the asynchronous PS/2 lines into the core clock domain. Both lines
// get a 2-FF synchroniser; the clock line additionally passes through a
// FILTER_LEN-sample glitch filter that produces a falling-edge strobe.
//
// Ports:
//   clk         core clock
//   reset_n     asynchronous active-low reset
//   ps2_clk_in  raw PS/2 clock line (idle high)
//   ps2_data_in raw PS/2 data line (idle high)
//   data_sync   synchronised data line
//   fall        one-cycle strobe when the filtered clock goes 1 -> 0
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   output logic data_sync,
   output logic fall
);

   logic [1:0]            clk_meta_reg;
   logic [1:0]            data_meta_reg;
   logic [FILTER_LEN-1:0] hist_reg;
   logic                  filt_reg;
   logic                  all_low;
   logic                  all_high;

   assign all_low  = ~|hist_reg;
   assign all_high = &hist_reg;

   // The strobe is raised in the cycle the filtered level is about to drop,
   // so the FSM sees it on the same edge that clears filt_reg.
   assign fall      = filt_reg & all_low;
   assign data_sync = data_meta_reg[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta_reg  <= 2'b11;
         data_meta_reg <= 2'b11;
         hist_reg      <= '1;
         filt_reg      <= 1'b1;
      end else begin
         clk_meta_reg  <= {clk_meta_reg[0], ps2_clk_in};
         data_meta_reg <= {data_meta_reg[0], ps2_data_in};
         hist_reg      <= {hist_reg[FILTER_LEN-2:0], clk_meta_reg[1]};
         // Level only moves when the whole history agrees; mixed history holds.
         if (all_low) begin
            filt_reg <= 1'b0;
         end else if (all_high) begin
            filt_reg <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_host_rx.sv
// ps2_host_rx
// PS/2 host-side receiver. Decodes 11-bit frames (start, 8 data LSB first,
// odd parity, stop) from the filtered PS/2 clock and buffers good bytes in a
// first-word-fall-through FIFO.
//
// Ports:
//   clk, reset_n     core clock, asynchronous active-low reset
//   ps2_clk_in       PS/2 clock line
//   ps2_data_in      PS/2 data line
//   rd               pop the FIFO head (ignored when empty)
//   dout             FIFO head byte, 8'h00 while empty
//   empty            FIFO holds no bytes
//   overflow         sticky, a good byte was dropped on a full FIFO
//   parity_err       one-cycle pulse on odd-parity failure
//   frame_err        one-cycle pulse on bad stop bit or inter-edge timeout
//   busy             receiver is inside a frame
module ps2_host_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 20000,
   parameter int FIFO_BITS  = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   input  logic       rd,
   output logic [7:0] dout,
   output logic       empty,
   output logic       overflow,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam int DEPTH = 2 ** FIFO_BITS;
   localparam int TW    = $clog2(TIMEOUT + 1);

   logic data_sync;
   logic fall;

   ps2_line_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_filter (
      .clk         (clk),
      .reset_n     (reset_n),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .data_sync   (data_sync),
      .fall        (fall)
   );

   // ---------------- frame FSM ----------------
   ps2_state_t      state_reg;
   logic [2:0]      bit_cnt_reg;
   logic [7:0]      shift_reg;
   logic            par_acc_reg;
   logic            par_ok_reg;
   logic [TW-1:0]   to_cnt_reg;
   logic            perr_reg;
   logic            ferr_reg;
   logic            push;
   logic            timeout_hit;

   // A good frame is pushed straight from the shift register on the stop edge.
   assign push = (state_reg == STOP) && fall &&
                 (data_sync == PS2_STOP_BIT) && par_ok_reg;

   // Counter holds TIMEOUT-1 during the TIMEOUT-th cycle after the edge that
   // closes the last fall cycle; the abort lands on the following edge.
   assign timeout_hit = (state_reg != IDLE) && !fall &&
                        (to_cnt_reg == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         par_acc_reg <= 1'b1;
         par_ok_reg  <= 1'b0;
         to_cnt_reg  <= '0;
         perr_reg    <= 1'b0;
         ferr_reg    <= 1'b0;
      end else begin
         perr_reg <= 1'b0;
         ferr_reg <= 1'b0;

         if (state_reg == IDLE || fall) begin
            to_cnt_reg <= '0;
         end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
         end

         case (state_reg)
            IDLE: begin
               // A fall with data high is a stray edge and is ignored.
               if (fall && data_sync == PS2_START_BIT) begin
                  state_reg   <= DATA;
                  bit_cnt_reg <= '0;
                  par_acc_reg <= 1'b1;
               end
            end
            DATA: begin
               if (fall) begin
                  shift_reg   <= {data_sync, shift_reg[7:1]};
                  par_acc_reg <= par_acc_reg ^ data_sync;
                  bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  if (bit_cnt_reg == 3'(PS2_DATA_BITS - 1)) begin
                     state_reg <= PARITY;
                  end
               end
            end
            PARITY: begin
               if (fall) begin
                  par_ok_reg <= (data_sync == par_acc_reg);
                  state_reg  <= STOP;
               end
            end
            STOP: begin
               if (fall) begin
                  // Framing failure takes precedence over a parity failure.
                  if (data_sync != PS2_STOP_BIT) begin
                     ferr_reg <= 1'b1;
                  end else if (!par_ok_reg) begin
                     perr_reg <= 1'b1;
                  end
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase

         if (timeout_hit) begin
            state_reg <= IDLE;
            ferr_reg  <= 1'b1;
            shift_reg <= '0;
         end
      end
   end

   assign busy       = (state_reg != IDLE);
   assign parity_err = perr_reg;
   assign frame_err  = ferr_reg;

   // ---------------- FWFT FIFO ----------------
   // Small enough for distributed storage, read combinationally so the head
   // byte is visible the cycle after it is written.
   logic [7:0]           mem [0:DEPTH-1];
   logic [FIFO_BITS-1:0] wr_ptr_reg;
   logic [FIFO_BITS-1:0] rd_ptr_reg;
   logic [FIFO_BITS:0]   count_reg;
   logic                 overflow_reg;
   logic                 full;
   logic                 rd_en;
   logic                 wr_en;

   assign empty = (count_reg == '0);
   // count never exceeds DEPTH, so its MSB alone marks full.
   assign full  = count_reg[FIFO_BITS];
   assign rd_en = rd && !empty;
   // On a full FIFO a same-cycle pop frees the slot the push needs.
   assign wr_en = push && (!full || rd_en);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_reg] <= shift_reg;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (rd_en) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (push && !wr_en) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign dout     = empty ? 8'h00 : mem[rd_ptr_reg];
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_ps2_host_rx.sv
module tb_ps2_host_rx;

   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 200;
   localparam int FIFO_BITS  = 3;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk_in = 1'b1;
   logic       ps2_data_in = 1'b1;
   logic       rd = 1'b0;
   logic [7:0] dout;
   logic       empty;
   logic       overflow;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int perr_cnt = 0;
   int ferr_cnt = 0;
   int busy_cnt = 0;
   int last_fall_cyc = 0;

   ps2_host_rx #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT    (TIMEOUT),
      .FIFO_BITS  (FIFO_BITS)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .rd          (rd),
      .dout        (dout),
      .empty       (empty),
      .overflow    (overflow),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse-width monitors: number of sampled cycles each output was high.
   always @(negedge clk) begin
      if (parity_err) perr_cnt <= perr_cnt + 1;
      if (frame_err)  ferr_cnt <= ferr_cnt + 1;
      if (busy)       busy_cnt <= busy_cnt + 1;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      logic       exp_push;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data_in = b;
      wait_cyc(10);
      ps2_clk_in = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(20);
      ps2_clk_in = 1'b1;
      wait_cyc(10);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(p);
      ps2_bit(s);
      ps2_data_in = 1'b1;
      wait_cyc(10);
   endtask

   task automatic pop;
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   initial begin
      int p0, f0, b0, t0, delay;
      logic found;
      logic [7:0] k8;

      vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      // Reset state
      wait_cyc(3);
      check("reset_busy", busy, 1'b0);
      check("reset_empty", empty, 1'b1);
      check("reset_dout", dout, 8'h00);
      check("reset_overflow", overflow, 1'b0);
      check("reset_parity_err", parity_err, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
      reset_n = 1'b1;
      wait_cyc(20);

      // Table-driven frames
      for (int v = 0; v < 9; v++) begin
         p0 = perr_cnt;
         f0 = ferr_cnt;
         send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
         $display("frame data=%02h par=%0b stop=%0b -> empty=%0b dout=%02h busy=%0b",
                  vecs[v].data, vecs[v].par, vecs[v].stop, empty, dout, busy);
         check($sformatf("vec%0d_parity_err_cycles", v), perr_cnt - p0, {31'd0, vecs[v].exp_perr});
         check($sformatf("vec%0d_frame_err_cycles", v), ferr_cnt - f0, {31'd0, vecs[v].exp_ferr});
         check($sformatf("vec%0d_busy", v), busy, 1'b0);
         check($sformatf("vec%0d_empty", v), empty, !vecs[v].exp_push);
         check($sformatf("vec%0d_dout", v), dout, vecs[v].exp_push ? vecs[v].data : 8'h00);
         if (vecs[v].exp_push) begin
            pop();
            check($sformatf("vec%0d_empty_after_rd", v), empty, 1'b1);
            check($sformatf("vec%0d_dout_after_rd", v), dout, 8'h00);
         end
      end

      // Timeout: clock stops after 4 data bits
      f0 = ferr_cnt;
      ps2_bit(1'b0);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      check("timeout_busy_before", busy, 1'b1);
      t0 = last_fall_cyc;
      found = 1'b0;
      for (int i = 0; i < 3 * TIMEOUT && !found; i++) begin
         if (frame_err) found = 1'b1;
         else @(negedge clk);
      end
      delay = cyc - t0;
      $display("timeout frame_err seen=%0b delay=%0d cycles after pin edge", found, delay);
      check("timeout_seen", found, 1'b1);
      check("timeout_delay", delay, 3 + FILTER_LEN + TIMEOUT);
      check("timeout_busy_after", busy, 1'b0);
      wait_cyc(5);
      check("timeout_frame_err_cycles", ferr_cnt - f0, 1);
      check("timeout_empty", empty, 1'b1);
      send_frame(8'hAA, 1'b1, 1'b1);
      $display("frame data=aa after timeout -> empty=%0b dout=%02h", empty, dout);
      check("after_timeout_dout", dout, 8'hAA);
      pop();
      check("after_timeout_empty", empty, 1'b1);

      // Overflow: 9 good frames into an 8-deep FIFO
      p0 = perr_cnt;
      for (int k = 1; k <= 9; k++) begin
         k8 = 8'(k);
         send_frame(k8, ~^k8, 1'b1);
         $display("frame data=%02h (fill) -> empty=%0b overflow=%0b", k8, empty, overflow);
         if (k == 8) check("fill8_overflow", overflow, 1'b0);
      end
      check("fill9_overflow", overflow, 1'b1);
      check("fill_parity_err", perr_cnt - p0, 0);
      for (int k = 1; k <= 8; k++) begin
         check($sformatf("drain%0d_empty", k), empty, 1'b0);
         check($sformatf("drain%0d_dout", k), dout, 8'(k));
         pop();
      end
      check("drain_empty", empty, 1'b1);
      check("drain_dout", dout, 8'h00);
      check("drain_overflow_sticky", overflow, 1'b1);

      // Short clock glitch and a stray edge with data high in IDLE
      b0 = busy_cnt;
      p0 = perr_cnt;
      f0 = ferr_cnt;
      ps2_clk_in = 1'b0;
      wait_cyc(3);
      ps2_clk_in = 1'b1;
      wait_cyc(30);
      $display("glitch 3 cycles -> busy_cycles=%0d", busy_cnt - b0);
      check("glitch_busy", busy_cnt - b0, 0);
      ps2_bit(1'b1);
      ps2_data_in = 1'b1;
      check("stray_edge_busy", busy_cnt - b0, 0);
      check("glitch_errors", (perr_cnt - p0) + (ferr_cnt - f0), 0);
      check("glitch_empty", empty, 1'b1);

      // Asynchronous reset mid-frame
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      check("midframe_busy", busy, 1'b1);
      reset_n = 1'b0;
      #1;
      $display("reset mid-frame -> busy=%0b empty=%0b overflow=%0b", busy, empty, overflow);
      check("async_reset_busy", busy, 1'b0);
      check("async_reset_empty", empty, 1'b1);
      check("async_reset_overflow", overflow, 1'b0);
      check("async_reset_dout", dout, 8'h00);
      wait_cyc(3);
      reset_n = 1'b1;
      wait_cyc(20);
      send_frame(8'h3C, 1'b1, 1'b1);
      $display("frame data=3c after reset -> empty=%0b dout=%02h", empty, dout);
      check("after_reset_empty", empty, 1'b0);
      check("after_reset_dout", dout, 8'h3C);
      pop();
      check("after_reset_drained", empty, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
